// File: rtl/dmix_pkg.sv
// Shared mixer definitions: frame sequencer states plus the saturating add
// and 24-bit clamp helpers also used by the resampler core.
package dmix_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    COLLECT = 3'd2,
    MIX     = 3'd3,
    SAT     = 3'd4,
    DONE    = 3'd5
  } mix_state_t;

  function automatic logic signed [31:0] sat_add32(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
    logic [32:0] sum;
    logic signed [31:0] res;
    sum = {a[31], a} + {b[31], b};
    // Overflow shows up as the two top bits of the 33-bit sum disagreeing.
    if (sum[32] != sum[31]) begin
      if (sum[32]) begin
        res = 32'sh8000_0000;
      end else begin
        res = 32'sh7FFF_FFFF;
      end
    end else begin
      res = sum[31:0];
    end
    return res;
  endfunction

  function automatic logic [23:0] clamp24(input logic signed [31:0] acc);
    logic [23:0] res;
    if (acc > 32'sh007F_FFFF) begin
      res = 24'h7F_FFFF;
    end else if (acc < 32'shFF80_0000) begin
      res = 24'h80_0000;
    end else begin
      res = acc[23:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/channel_mixer_if.sv
// Resampler/mixer handshake and control bundle; slave is the mixer side.
interface channel_mixer_if #(
  parameter int NUM_CH = 8
) ();
  logic                   tick_i;
  logic [NUM_CH-1:0]      pop_o;
  logic [23:0]            data_i;
  logic [NUM_CH-1:0]      ack_i;
  logic [16*NUM_CH-1:0]   vol_i;
  logic [NUM_CH-1:0]      route_i;
  logic [23:0]            data_l_o;
  logic [23:0]            data_r_o;
  logic                   valid_o;
  logic [NUM_CH-1:0]      underrun_o;
  logic                   overrun_o;

  modport master (
    output tick_i, data_i, ack_i, vol_i, route_i,
    input  pop_o, data_l_o, data_r_o, valid_o, underrun_o, overrun_o
  );

  modport slave (
    input  tick_i, data_i, ack_i, vol_i, route_i,
    output pop_o, data_l_o, data_r_o, valid_o, underrun_o, overrun_o
  );
endinterface

// File: rtl/channel_mixer_mix_mac.sv
// Single-cycle gain/accumulate lane: scales one sample by an unsigned Q1.15
// gain and saturating-adds it into the left or right accumulator.
module mix_mac
  import dmix_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic signed [23:0] sample,
  input  logic [15:0]        vol,
  input  logic               route,
  input  logic               active,
  output logic signed [31:0] acc_l,
  output logic signed [31:0] acc_r
);

  logic signed [40:0] prod_s;
  logic signed [31:0] term_s;

  // Gain is zero-extended so 0xFFFF stays positive (just under 2x).
  assign prod_s = sample * $signed({1'b0, vol});
  assign term_s = active ? 32'(prod_s >>> 15) : 32'sh0000_0000;

  // Accumulator pair, cleared at frame start.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_l <= 32'sh0000_0000;
      acc_r <= 32'sh0000_0000;
    end else if (en) begin
      if (route) begin
        acc_r <= sat_add32(acc_r, term_s);
      end else begin
        acc_l <= sat_add32(acc_l, term_s);
      end
    end
  end

endmodule

// File: rtl/channel_mixer.sv
// Stereo channel mixer: pops every resampler channel once per output tick,
// collects the acks, then mixes and clamps the channels into a left/right pair.
module channel_mixer
  import dmix_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int NUM_CH_LOG2  = 3,
  parameter int TIMEOUT      = 1024,
  parameter int TIMEOUT_LOG2 = 10
) (
  input  logic            clk,
  input  logic            rst,
  channel_mixer_if.slave  bus
);

  mix_state_t              state_r;
  logic [NUM_CH-1:0]       pop_r;
  logic [NUM_CH-1:0]       received_r;
  logic [NUM_CH-1:0]       underrun_r;
  logic                    valid_r;
  logic                    overrun_r;
  logic [23:0]             data_l_r;
  logic [23:0]             data_r_r;
  logic signed [23:0]      sample_r [NUM_CH];
  logic [TIMEOUT_LOG2-1:0] timeout_r;
  logic [NUM_CH_LOG2-1:0]  mix_idx_r;

  logic [NUM_CH-1:0]       ack_low_s;
  logic                    all_rcv_s;
  logic                    mac_clr_s;
  logic                    mac_en_s;
  logic signed [31:0]      acc_l_s;
  logic signed [31:0]      acc_r_s;

  // Isolate the lowest set ack bit so a malformed strobe captures one channel.
  assign ack_low_s = bus.ack_i & (~bus.ack_i + NUM_CH'(1'b1));
  assign all_rcv_s = &received_r;
  assign mac_clr_s = (state_r == IDLE) && bus.tick_i;
  assign mac_en_s  = (state_r == MIX);

  mix_mac u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr_s),
    .en     (mac_en_s),
    .sample (sample_r[mix_idx_r]),
    .vol    (bus.vol_i[{mix_idx_r, 4'b0000} +: 16]),
    .route  (bus.route_i[mix_idx_r]),
    .active (received_r[mix_idx_r]),
    .acc_l  (acc_l_s),
    .acc_r  (acc_r_s)
  );

  // Frame sequencer with its handshake, capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pop_r      <= {NUM_CH{1'b0}};
      received_r <= {NUM_CH{1'b0}};
      underrun_r <= {NUM_CH{1'b0}};
      valid_r    <= 1'b0;
      overrun_r  <= 1'b0;
      data_l_r   <= 24'h00_0000;
      data_r_r   <= 24'h00_0000;
      timeout_r  <= {TIMEOUT_LOG2{1'b0}};
      mix_idx_r  <= {NUM_CH_LOG2{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
        sample_r[k] <= 24'sh00_0000;
      end
    end else begin
      pop_r     <= {NUM_CH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= bus.tick_i && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (bus.tick_i) begin
            state_r    <= POP;
            pop_r      <= {NUM_CH{1'b1}};
            received_r <= {NUM_CH{1'b0}};
          end
        end
        POP: begin
          timeout_r <= {TIMEOUT_LOG2{1'b0}};
          state_r   <= COLLECT;
        end
        COLLECT: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ack_low_s[k] && !received_r[k]) begin
              received_r[k] <= 1'b1;
              sample_r[k]   <= bus.data_i;
            end
          end
          timeout_r <= timeout_r + TIMEOUT_LOG2'(1'b1);
          if (all_rcv_s || (timeout_r == TIMEOUT_LOG2'(TIMEOUT - 1))) begin
            state_r   <= MIX;
            mix_idx_r <= {NUM_CH_LOG2{1'b0}};
          end
        end
        MIX: begin
          mix_idx_r <= mix_idx_r + NUM_CH_LOG2'(1'b1);
          if (mix_idx_r == NUM_CH_LOG2'(NUM_CH - 1)) begin
            state_r <= SAT;
          end
        end
        SAT: begin
          // Results and underrun map become visible together with valid in DONE.
          data_l_r   <= clamp24(acc_l_s);
          data_r_r   <= clamp24(acc_r_s);
          underrun_r <= ~received_r;
          valid_r    <= 1'b1;
          state_r    <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.pop_o      = pop_r;
  assign bus.valid_o    = valid_r;
  assign bus.overrun_o  = overrun_r;
  assign bus.data_l_o   = data_l_r;
  assign bus.data_r_o   = data_r_r;
  assign bus.underrun_o = underrun_r;

endmodule

// File: tb/tb_channel_mixer.sv
// Bench for channel_mixer: fixed frame vectors, overrun/reset sequences and
// randomized frames checked against an arithmetic reference of the mix rules.
module tb_channel_mixer;

  localparam int NUM_CH       = 8;
  localparam int NUM_CH_LOG2  = 3;
  localparam int TIMEOUT      = 1024;
  localparam int TIMEOUT_LOG2 = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  channel_mixer_if #(.NUM_CH(NUM_CH)) bus ();

  channel_mixer #(
    .NUM_CH(NUM_CH), .NUM_CH_LOG2(NUM_CH_LOG2),
    .TIMEOUT(TIMEOUT), .TIMEOUT_LOG2(TIMEOUT_LOG2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [24*NUM_CH-1:0] smp;
    logic [NUM_CH-1:0]    mask;
    logic [16*NUM_CH-1:0] vol;
    logic [NUM_CH-1:0]    route;
    logic [23:0]          exp_l;
    logic [23:0]          exp_r;
    logic [NUM_CH-1:0]    exp_u;
  } vec_t;

  vec_t tbl [6];

  int n_cmp = 0;
  int n_bad = 0;

  // Ack schedule for one frame; entry i is driven i cycles after the pop cycle.
  logic [NUM_CH-1:0]    sch_ack [0:63];
  logic [23:0]          sch_dat [0:63];
  int                   sch_len;
  logic [16*NUM_CH-1:0] f_vol;
  logic [NUM_CH-1:0]    f_route;
  logic [NUM_CH-1:0]    all_ones;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [23:0] clamp_ref(input longint v);
    if (v > 64'sd8388607) return 24'h7FFFFF;
    if (v < -64'sd8388608) return 24'h800000;
    return 24'(v);
  endfunction

  task automatic push(input logic [NUM_CH-1:0] a, input logic [23:0] d);
    sch_len++;
    sch_ack[sch_len] = a;
    sch_dat[sch_len] = d;
  endtask

  // Reference: first ack per channel wins (lowest set bit), then gain/route sums.
  task automatic model_frame(output logic [23:0] el, output logic [23:0] er,
                             output logic [NUM_CH-1:0] eu, output int evoff);
    bit     rcv [NUM_CH];
    longint smp [NUM_CH];
    longint acc [2];
    longint term;
    int     last;
    int     j;
    bit     all;
    last = -1;
    acc[0] = 0;
    acc[1] = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      rcv[c] = 1'b0;
      smp[c] = 0;
    end
    for (int i = 1; i <= sch_len && i <= TIMEOUT; i++) begin
      j = -1;
      for (int c = NUM_CH - 1; c >= 0; c--) if (sch_ack[i][c]) j = c;
      if (j >= 0 && !rcv[j]) begin
        rcv[j] = 1'b1;
        smp[j] = longint'($signed(sch_dat[i]));
      end
      all = 1'b1;
      for (int c = 0; c < NUM_CH; c++) if (!rcv[c]) all = 1'b0;
      if (all && last < 0) last = i;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      term = rcv[c] ? ((smp[c] * longint'(f_vol[16*c +: 16])) >>> 15) : 0;
      acc[int'(f_route[c])] = sat32(acc[int'(f_route[c])] + term);
    end
    el = clamp_ref(acc[0]);
    er = clamp_ref(acc[1]);
    for (int c = 0; c < NUM_CH; c++) eu[c] = !rcv[c];
    evoff = (last >= 0) ? last + NUM_CH + 3 : TIMEOUT + NUM_CH + 2;
  endtask

  task automatic sched_from_vec(input vec_t v, output int evoff);
    logic [NUM_CH-1:0] oh;
    sch_len = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (v.mask[c]) begin
        oh = '0;
        oh[c] = 1'b1;
        push(oh, v.smp[24*c +: 24]);
      end
    end
    f_vol   = v.vol;
    f_route = v.route;
    evoff = (v.mask == all_ones) ? sch_len + NUM_CH + 3 : TIMEOUT + NUM_CH + 2;
  endtask

  task automatic build_random(input bit drop);
    int perm [NUM_CH];
    int tmp;
    int j;
    int drop_ch;
    logic [NUM_CH-1:0] one_v;
    logic [NUM_CH-1:0] hi;
    logic [NUM_CH-1:0] a;
    logic [23:0] d;
    one_v = 1;
    for (int i = 0; i < NUM_CH; i++) perm[i] = i;
    for (int i = NUM_CH - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    drop_ch = drop ? int'($urandom_range(NUM_CH - 1, 0)) : -1;
    for (int c = 0; c < NUM_CH; c++) begin
      case ($urandom_range(3, 0))
        0: f_vol[16*c +: 16] = 16'h8000;
        1: f_vol[16*c +: 16] = 16'hFFFF;
        default: f_vol[16*c +: 16] = 16'($urandom);
      endcase
    end
    f_route = NUM_CH'($urandom);
    sch_len = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (perm[i] != drop_ch) begin
        repeat ($urandom_range(2, 0)) push('0, 24'($urandom));
        case ($urandom_range(3, 0))
          0: d = 24'h7FFFFF;
          1: d = 24'h800000;
          default: d = 24'($urandom);
        endcase
        a = one_v << perm[i];
        hi = ~((one_v << (perm[i] + 1)) - one_v);
        if ($urandom_range(2, 0) == 0) a = a | (NUM_CH'($urandom) & hi);
        push(a, d);
        if (i > 0 && perm[i-1] != drop_ch && $urandom_range(3, 0) == 0)
          push(one_v << perm[i-1], 24'($urandom));
      end
    end
  endtask

  // Starts a frame at the current negedge and watches it cycle by cycle.
  task automatic run_frame(input string nm, input logic [23:0] el, input logic [23:0] er,
                           input logic [NUM_CH-1:0] eu, input int evoff,
                           input int tick_off, input int tail);
    int valid_at = -1;
    int valid_cnt = 0;
    int ov_cnt = 0;
    int ov_at = -1;
    int pop_cnt = 0;
    logic [23:0] al = '0;
    logic [23:0] ar = '0;
    logic [NUM_CH-1:0] au = '0;
    bus.vol_i   = f_vol;
    bus.route_i = f_route;
    bus.tick_i  = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    check({nm, "/pop_start"}, 32'(bus.pop_o), 32'(all_ones));
    bus.ack_i  = all_ones;
    bus.data_i = 24'h5A5A5A;
    for (int i = 1; i <= evoff + tail; i++) begin
      @(negedge clk);
      if (bus.pop_o != '0) pop_cnt++;
      if (bus.overrun_o) begin ov_cnt++; ov_at = i; end
      if (bus.valid_o) begin
        valid_cnt++;
        if (valid_at < 0) begin
          valid_at = i;
          al = bus.data_l_o;
          ar = bus.data_r_o;
          au = bus.underrun_o;
        end
      end
      bus.ack_i  = (i <= sch_len) ? sch_ack[i] : '0;
      bus.data_i = (i <= sch_len) ? sch_dat[i] : 24'h0;
      bus.tick_i = (i == tick_off);
    end
    bus.tick_i = 1'b0;
    bus.ack_i  = '0;
    check({nm, "/valid_at"}, 32'(valid_at), 32'(evoff));
    check({nm, "/valid_cnt"}, 32'(valid_cnt), 32'd1);
    check({nm, "/data_l"}, 32'(al), 32'(el));
    check({nm, "/data_r"}, 32'(ar), 32'(er));
    check({nm, "/underrun"}, 32'(au), 32'(eu));
    check({nm, "/hold_l"}, 32'(bus.data_l_o), 32'(el));
    check({nm, "/hold_u"}, 32'(bus.underrun_o), 32'(eu));
    check({nm, "/extra_pop"}, 32'(pop_cnt), 32'd0);
    check({nm, "/overrun_cnt"}, 32'(ov_cnt), (tick_off >= 1) ? 32'd1 : 32'd0);
    if (tick_off >= 1) check({nm, "/overrun_at"}, 32'(ov_at), 32'(tick_off + 1));
  endtask

  task automatic check_zero(input string nm);
    check({nm, "/pop"}, 32'(bus.pop_o), 32'd0);
    check({nm, "/valid"}, 32'(bus.valid_o), 32'd0);
    check({nm, "/overrun"}, 32'(bus.overrun_o), 32'd0);
    check({nm, "/data_l"}, 32'(bus.data_l_o), 32'd0);
    check({nm, "/data_r"}, 32'(bus.data_r_o), 32'd0);
    check({nm, "/underrun"}, 32'(bus.underrun_o), 32'd0);
  endtask

  initial begin
    logic [23:0] el;
    logic [23:0] er;
    logic [NUM_CH-1:0] eu;
    int evoff;

    all_ones = '1;
    for (int t = 0; t < 6; t++) begin
      tbl[t].smp   = '0;
      tbl[t].mask  = '1;
      tbl[t].vol   = {NUM_CH{16'h8000}};
      tbl[t].route = '0;
      tbl[t].exp_l = 24'h0;
      tbl[t].exp_r = 24'h0;
      tbl[t].exp_u = '0;
    end
    tbl[0].smp[0 +: 24] = 24'h100000;  tbl[0].exp_l = 24'h100000;
    tbl[1].smp[48 +: 24] = 24'h400000; tbl[1].vol[32 +: 16] = 16'h4000;
    tbl[1].route[2] = 1'b1;            tbl[1].exp_r = 24'h200000;
    tbl[2].smp = {NUM_CH{24'h7FFFFF}}; tbl[2].exp_l = 24'h7FFFFF;
    tbl[3].smp = {NUM_CH{24'h800000}}; tbl[3].exp_l = 24'h800000;
    tbl[4].smp[0 +: 24] = 24'h000010;  tbl[4].smp[120 +: 24] = 24'h100000;
    tbl[4].mask = 8'hDF; tbl[4].exp_l = 24'h000010; tbl[4].exp_u = 8'h20;
    tbl[5].smp[24 +: 24]  = 24'hFFFF00; tbl[5].vol[16 +: 16]  = 16'hFFFF; tbl[5].route[1] = 1'b1;
    tbl[5].smp[72 +: 24]  = 24'h012345; tbl[5].route[3] = 1'b1;
    tbl[5].smp[144 +: 24] = 24'hC00000; tbl[5].vol[96 +: 16]  = 16'h2000;
    tbl[5].smp[168 +: 24] = 24'h000003; tbl[5].vol[112 +: 16] = 16'h0001;
    tbl[5].exp_l = 24'hF00000; tbl[5].exp_r = 24'h012145;

    rst = 1'b1;
    bus.tick_i = 1'b0; bus.ack_i = '0; bus.data_i = 24'h0;
    bus.vol_i = '0; bus.route_i = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    bus.ack_i = all_ones;
    bus.data_i = 24'h123456;
    @(negedge clk);
    bus.ack_i = '0;

    for (int t = 0; t < 6; t++) begin
      sched_from_vec(tbl[t], evoff);
      run_frame($sformatf("tbl%0d", t), tbl[t].exp_l, tbl[t].exp_r, tbl[t].exp_u, evoff, -1, 4);
    end

    // Second tick while mixing: dropped with a single overrun pulse.
    sched_from_vec(tbl[0], evoff);
    run_frame("ovr_mix", tbl[0].exp_l, tbl[0].exp_r, tbl[0].exp_u, evoff, evoff - 5, 4);
    // Tick during DONE is an overrun; the very next cycle's tick starts a frame.
    sched_from_vec(tbl[1], evoff);
    run_frame("ovr_done", tbl[1].exp_l, tbl[1].exp_r, tbl[1].exp_u, evoff, evoff, 1);
    sched_from_vec(tbl[2], evoff);
    run_frame("after_done", tbl[2].exp_l, tbl[2].exp_r, tbl[2].exp_u, evoff, -1, 4);

    // Reset in the middle of COLLECT.
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    @(negedge clk);
    bus.ack_i = 8'h01; bus.data_i = 24'h111111;
    @(negedge clk);
    bus.ack_i = 8'h02; bus.data_i = 24'h222222;
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    bus.ack_i = all_ones; bus.data_i = 24'h333333;
    @(negedge clk);
    bus.ack_i = '0;
    sched_from_vec(tbl[5], evoff);
    run_frame("post_rst", tbl[5].exp_l, tbl[5].exp_r, tbl[5].exp_u, evoff, -1, 4);

    for (int f = 0; f < 20; f++) begin
      build_random(f % 5 == 4);
      model_frame(el, er, eu, evoff);
      run_frame($sformatf("rnd%0d", f), el, er, eu, evoff, -1, 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/channel_mixer.md
CHANNEL_MIXER -- requirements
Module: channel_mixer

Interface
REQ-001 The block SHALL provide parameter NUM_CH, default 8: number of resampled input channels.
REQ-002 The block SHALL provide parameter NUM_CH_LOG2, default 3: channel index width.
REQ-003 The block SHALL provide parameter TIMEOUT, default 1024: maximum number of collect cycles per output frame.
REQ-004 The block SHALL provide parameter TIMEOUT_LOG2, default 10: width of the timeout counter.
REQ-005 The block SHALL use clock clk and reset rst, which is synchronous and active-high.
REQ-006 The block SHALL provide these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tick_i  in  1  output-sample-rate strobe, one cycle wide
- pop_o  out  NUM_CH  pop request to the resampler core, one per channel
- data_i  in  24  resampled sample, signed, shared bus
- ack_i  in  NUM_CH  one-hot strobe; data_i is valid in the same cycle
- vol_i  in  16*NUM_CH  per-channel gain, unsigned Q1.15, 0x8000 = unity
- route_i  in  NUM_CH  per-channel destination, 0 = left, 1 = right
- data_l_o  out  24  left mix, signed
- data_r_o  out  24  right mix, signed
- valid_o  out  1  one-cycle strobe indicating data_l_o/data_r_o are updated
- underrun_o  out  NUM_CH  channels that did not ack in the last frame
- overrun_o  out  1  one-cycle pulse when tick_i is dropped

Function
REQ-007 The FSM SHALL have these states: IDLE, POP, COLLECT, MIX, SAT, DONE.
REQ-008 In IDLE, when tick_i=1, the FSM SHALL move to POP and clear all received flags and both accumulators.
REQ-009 In POP, pop_o SHALL be all-ones for exactly one cycle; the timeout counter SHALL be cleared; the next state SHALL be COLLECT.
REQ-010 In COLLECT, for each cycle in which ack_i[k]=1, the block SHALL capture data_i into sample[k] and set received[k].
- A repeated ack for an already-received channel SHALL be ignored.
- If ack_i is not one-hot, only the lowest set index SHALL be taken.
REQ-011 The FSM SHALL leave COLLECT for MIX in the cycle after received becomes all-ones, or when the timeout counter reaches TIMEOUT-1, whichever occurs first.
REQ-012 ack_i SHALL be ignored in every state other than COLLECT.
REQ-013 MIX SHALL last exactly NUM_CH cycles and process channel c = 0..NUM_CH-1 in order, one channel per cycle:
- product = signed sample[c] * signed {0, vol[c]}, full 41-bit width;
- term = product >>> 15, sign-extended to 32 bits;
- term SHALL be added with saturation (limits 0x7FFF_FFFF / 0x8000_0000) to acc_r if route[c]=1, otherwise to acc_l;
- a non-received channel SHALL contribute 0.
REQ-014 vol_i and route_i SHALL be sampled during MIX; changes made mid-frame SHALL take effect only for channels not yet processed.
REQ-015 SAT SHALL last one cycle and clamp each accumulator to 24 bits: values above 0x7FFFFF become 0x7FFFFF, values below -0x800000 become 0x800000, otherwise the low 24 bits are kept. The results SHALL be registered into data_l_o and data_r_o.
REQ-016 In DONE, valid_o SHALL be 1 for one cycle and underrun_o SHALL be loaded with ~received; the next state SHALL be IDLE.
REQ-017 data_l_o, data_r_o and underrun_o SHALL hold their values until the next DONE.
REQ-018 A tick_i arriving in any state other than IDLE SHALL be dropped and SHALL produce overrun_o=1 in the following cycle.
REQ-019 Latency from the COLLECT exit condition to valid_o SHALL be NUM_CH+3 cycles (one exit cycle, NUM_CH MIX cycles, one SAT cycle, one DONE cycle).
REQ-020 A tick_i coinciding with DONE SHALL be treated as an overrun; a tick_i in the cycle after DONE SHALL be accepted.

Reset
REQ-021 While rst=1, the FSM SHALL enter IDLE within the same clock edge, including from the middle of a frame.
REQ-022 Reset SHALL force pop_o=0, valid_o=0, overrun_o=0, data_l_o=0, data_r_o=0 and underrun_o=0.
REQ-023 Reset SHALL clear received, both accumulators and the timeout counter.
REQ-024 Any ack_i in the cycle after reset is released SHALL be ignored.

Structure
REQ-025 The shared package dmix_pkg SHALL hold the FSM state constants, the 32-bit saturating-add function (shared with the resampler core) and the 32-to-24-bit clamp function.
REQ-026 The block SHALL contain one sub-module, mix_mac: a single-cycle multiply/shift/saturating-accumulate lane with two accumulators selected by a route bit.

Verification
REQ-027 Unity path: vol=0x8000 and route=0 on all channels, ch0 acks 0x100000, others ack 0 -> data_l_o=0x100000, data_r_o=0, valid_o exactly NUM_CH+3 cycles after the last ack.
REQ-028 Gain and routing: ch2 acks 0x400000 with vol=0x4000, route=1 -> data_r_o=0x200000, data_l_o=0.
REQ-029 Saturation: all 8 channels ack 0x7FFFFF, vol=0x8000, route=0 -> data_l_o=0x7FFFFF; the same test with 0x800000 -> data_l_o=0x800000.
REQ-030 Underrun: ch5 never acks -> COLLECT exits after TIMEOUT cycles, underrun_o=0x20 and ch5 contributes 0 to the mix.
REQ-031 Overrun and reset: a second tick_i during MIX -> one overrun_o pulse and no extra frame; rst asserted during COLLECT -> outputs are zero next cycle and the next tick_i runs a clean frame.
